// File: rtl/period_meter.sv
// rtl/period_meter.sv - rising-edge period meter with timeout flag
// Optional high-time output enabled by defining PERIOD_METER_HIGH_TIME_EN.
module period_meter #(
  parameter int                     COUNT_WIDTH = 32,
  parameter logic [COUNT_WIDTH-1:0] MAX_COUNT   = COUNT_WIDTH'(12_000_000 - 1)
) (
  input  logic                   clk,
  input  logic                   rst_btn,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   valid,
  output logic                   timeout
`ifdef PERIOD_METER_HIGH_TIME_EN
  ,
  output logic [COUNT_WIDTH-1:0] high_time
`endif
);

  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 state;
  logic                   sync1, sync2, prev;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   rise;

  assign rise = sync2 & ~prev;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Counter runs in every state; it saturates so TIMEOUT holds MAX_COUNT.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != MAX_COUNT) begin
      cnt <= cnt + CNT_ONE;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic                   fall;
  logic                   fell;
  logic [COUNT_WIDTH-1:0] hcnt;
  logic [COUNT_WIDTH-1:0] hreg;

  assign fall = ~sync2 & prev;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      hcnt <= '0;
      hreg <= '0;
      fell <= 1'b0;
    end else begin
      if (rise) begin
        hcnt <= CNT_ONE;
      end else if (sync2 && hcnt != MAX_COUNT) begin
        hcnt <= hcnt + CNT_ONE;
      end
      if (rise) begin
        fell <= 1'b0;
      end else if (fall && state == MEASURE) begin
        hreg <= hcnt;
        fell <= 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state     <= IDLE;
      period    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
`ifdef PERIOD_METER_HIGH_TIME_EN
      high_time <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= MEASURE;
        end
        MEASURE: begin
          // A rise coinciding with saturation is still a valid measurement.
          if (rise) begin
            period <= cnt;
            valid  <= 1'b1;
`ifdef PERIOD_METER_HIGH_TIME_EN
            high_time <= fell ? hreg : cnt;
`endif
          end else if (cnt == MAX_COUNT) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
          end
        end
        TIMEOUT: begin
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
// Also checks high_time when built with PERIOD_METER_HIGH_TIME_EN.
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst_btn = 1'b0;
  logic        sig_in = 1'b0;
  logic [31:0] period;
  logic        valid;
  logic        timeout;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [31:0] high_time;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  int          cycle = 0;
  int          vcount = 0;
  int          last_vcycle = 0;
  int          last_gap = 0;
  int          dbl = 0;
  logic        tseen = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_period = '0;
`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [31:0] last_high = '0;
`endif

  period_meter #(.COUNT_WIDTH(32), .MAX_COUNT(32'd1000)) dut (
    .clk       (clk),
    .rst_btn   (rst_btn),
    .sig_in    (sig_in),
    .period    (period),
    .valid     (valid),
    .timeout   (timeout)
`ifdef PERIOD_METER_HIGH_TIME_EN
    ,
    .high_time (high_time)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      last_gap    = cycle - last_vcycle;
      last_vcycle = cycle;
      last_period = period;
`ifdef PERIOD_METER_HIGH_TIME_EN
      last_high   = high_time;
`endif
      if (prev_valid) dbl++;
    end
    if (timeout) tseen = 1'b1;
    prev_valid = valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic clear_mon();
    vcount = 0;
    dbl    = 0;
    tseen  = 1'b0;
  endtask

  task automatic do_reset();
    sig_in  = 1'b0;
    rst_btn = 1'b0;
    cycles(3);
    rst_btn = 1'b1;
    cycles(3);
    clear_mon();
  endtask

  task automatic square(input int hi, input int lo, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      cycles(hi);
      sig_in = 1'b0;
      cycles(lo);
    end
  endtask

  task automatic test_reset();
    sig_in  = 1'b0;
    rst_btn = 1'b0;
    cycles(3);
    check("reset_period", period, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    rst_btn = 1'b1;
    cycles(2);
    clear_mon();
    sig_in = 1'b1;
    cycles(20);
    check("first_rise_no_valid", vcount, 32'd0);
    sig_in = 1'b0;
    cycles(5);
  endtask

  task automatic test_period_100();
    do_reset();
    square(50, 50, 5);
    cycles(10);
    check("p100_valid_count", vcount, 32'd4);
    check("p100_period", last_period, 32'd100);
    check("p100_gap", last_gap, 32'd100);
    check("p100_no_double", dbl, 32'd0);
    check("p100_no_timeout", {31'd0, tseen}, 32'd0);
`ifdef PERIOD_METER_HIGH_TIME_EN
    check("p100_high_time", last_high, 32'd50);
`endif
  endtask

  task automatic test_period_2();
    do_reset();
    square(1, 1, 8);
    cycles(10);
    check("p2_valid_count", vcount, 32'd7);
    check("p2_period", last_period, 32'd2);
    check("p2_gap", last_gap, 32'd2);
`ifdef PERIOD_METER_HIGH_TIME_EN
    check("p2_high_time", last_high, 32'd1);
`endif
  endtask

  task automatic test_period_37();
    do_reset();
    square(10, 27, 4);
    cycles(10);
    check("p37_valid_count", vcount, 32'd3);
    check("p37_period", last_period, 32'd37);
`ifdef PERIOD_METER_HIGH_TIME_EN
    check("p37_high_time", last_high, 32'd10);
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    square(50, 50, 2);
    cycles(800);
    check("to_not_yet", {31'd0, timeout}, 32'd0);
    cycles(200);
    check("to_raised", {31'd0, timeout}, 32'd1);
    check("to_period_held", period, 32'd100);
    sig_in = 1'b1;
    cycles(5);
    check("to_cleared", {31'd0, timeout}, 32'd0);
    check("to_first_edge_no_valid", vcount, 32'd1);
    cycles(145);
    sig_in = 1'b0;
    cycles(150);
    sig_in = 1'b1;
    cycles(5);
    check("to_second_edge_valid", vcount, 32'd2);
    check("to_period_300", last_period, 32'd300);
`ifdef PERIOD_METER_HIGH_TIME_EN
    check("to_high_time_150", last_high, 32'd150);
`endif
    sig_in = 1'b0;
    cycles(5);
  endtask

  task automatic test_max_edges();
    do_reset();
    square(500, 500, 2);
    sig_in = 1'b1;
    cycles(5);
    check("max_valid_count", vcount, 32'd2);
    check("max_period", last_period, 32'd1000);
    check("max_no_timeout", {31'd0, tseen}, 32'd0);
    sig_in = 1'b0;
    do_reset();
    square(500, 501, 2);
    sig_in = 1'b1;
    cycles(5);
    check("over_max_no_valid", vcount, 32'd0);
    check("over_max_timeout_seen", {31'd0, tseen}, 32'd1);
    check("over_max_timeout_cleared", {31'd0, timeout}, 32'd0);
    sig_in = 1'b0;
    cycles(5);
  endtask

  task automatic test_async_reset();
    do_reset();
    square(50, 50, 2);
    sig_in = 1'b1;
    cycles(20);
    check("ar_period_before", period, 32'd100);
    @(posedge clk);
    #3 rst_btn = 1'b0;
    sig_in = 1'b0;
    #1;
    check("ar_period_zero", period, 32'd0);
    check("ar_valid_zero", {31'd0, valid}, 32'd0);
    check("ar_timeout_zero", {31'd0, timeout}, 32'd0);
    cycles(2);
    rst_btn = 1'b1;
    cycles(2);
    clear_mon();
    square(50, 50, 1);
    check("ar_arm_only", vcount, 32'd0);
    square(50, 50, 2);
    cycles(10);
    check("ar_valid_count", vcount, 32'd2);
    check("ar_period", last_period, 32'd100);
  endtask

  initial begin
    test_reset();
    test_period_100();
    test_period_2();
    test_period_37();
    test_timeout();
    test_max_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
